// File: rtl/snake_pkg.sv
// Shared direction, pixel-class, game-status and FSM types for the snake engine.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    SHOW_NONE = 2'b00,
    SHOW_HEAD = 2'b01,
    SHOW_BODY = 2'b10,
    SHOW_WALL = 2'b11
  } show_t;

  typedef enum logic [1:0] {
    GS_RESTART = 2'b00,
    GS_HOLD    = 2'b01,
    GS_PLAY    = 2'b10,
    GS_DIE     = 2'b11
  } gs_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DEAD} state_t;

  function automatic dir_t rev_dir(input dir_t d);
    case (d)
      DIR_UP:   rev_dir = DIR_DOWN;
      DIR_DOWN: rev_dir = DIR_UP;
      DIR_LEFT: rev_dir = DIR_RIGHT;
      default:  rev_dir = DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_dir_queue.sv
// Falling-edge key capture into a 2-entry direction FIFO with reversal/duplicate filter.
// Key fall to queued entry: 1 cycle; new keys are dropped while the FIFO is full.
module snake_dir_queue
  import snake_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear,
  input  logic [3:0] i_key_n,
  input  logic       i_pop,
  input  dir_t       i_cur_dir,
  output logic       o_vld,
  output dir_t       o_dir
);

  logic [3:0] r_key_q;
  dir_t       r_ent0, r_ent1;
  logic [1:0] r_cnt;

  logic [3:0] w_fall;
  logic       w_new_vld;
  dir_t       w_new_dir, w_ref, w_ent0_nxt, w_ent1_nxt;
  logic [1:0] w_cnt_nxt;

  // i_key_n order is {up, down, left, right}; keys are active-low
  assign w_fall    = r_key_q & ~i_key_n;
  assign w_new_vld = |w_fall;

  always_comb begin
    w_new_dir = DIR_RIGHT;
    if (w_fall[3])      w_new_dir = DIR_UP;
    else if (w_fall[2]) w_new_dir = DIR_DOWN;
    else if (w_fall[1]) w_new_dir = DIR_LEFT;

    w_ref = i_cur_dir;
    if (r_cnt == 2'd2)      w_ref = r_ent1;
    else if (r_cnt == 2'd1) w_ref = r_ent0;

    w_ent0_nxt = r_ent0;
    w_ent1_nxt = r_ent1;
    w_cnt_nxt  = r_cnt;
    if (i_pop && r_cnt != 2'd0) begin
      w_ent0_nxt = r_ent1;
      w_cnt_nxt  = r_cnt - 2'd1;
    end
    if (w_new_vld && w_new_dir != w_ref && w_new_dir != rev_dir(w_ref) && w_cnt_nxt != 2'd2) begin
      if (w_cnt_nxt == 2'd0) w_ent0_nxt = w_new_dir;
      else                   w_ent1_nxt = w_new_dir;
      w_cnt_nxt = w_cnt_nxt + 2'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_key_q <= 4'hF;
      r_cnt   <= 2'd0;
      r_ent0  <= DIR_RIGHT;
      r_ent1  <= DIR_RIGHT;
    end else begin
      r_key_q <= i_key_n;
      if (i_clear) begin
        r_cnt <= 2'd0;
      end else begin
        r_cnt  <= w_cnt_nxt;
        r_ent0 <= w_ent0_nxt;
        r_ent1 <= w_ent1_nxt;
      end
    end
  end

  assign o_vld = (r_cnt != 2'd0);
  assign o_dir = r_ent0;

endmodule

// File: rtl/snake_engine.sv
// Snake movement, growth and collision engine with a registered per-pixel classifier.
// Moves once per speed period in RUN; snake_show lags pos_x/pos_y by 1 cycle; no backpressure.
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30,
  parameter int CELL_SHIFT = 4,
  parameter int MAX_LEN    = 32,
  parameter int INIT_LEN   = 5,
  parameter int INIT_X     = 10,
  parameter int INIT_Y     = 5,
  parameter int TICK_W     = 24,
  parameter int PERIOD0    = 12500000,
  parameter int PERIOD1    = 6250000,
  parameter int PERIOD2    = 3125000,
  parameter int PERIOD3    = 1562500,
  localparam int X_W       = $clog2(GRID_W),
  localparam int Y_W       = $clog2(GRID_H),
  localparam int L_W       = $clog2(MAX_LEN + 1)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [1:0]     i_game_status,
  input  logic [1:0]     i_speed_sel,
  input  logic           i_wrap_mode,
  input  logic           i_key_right,
  input  logic           i_key_left,
  input  logic           i_key_down,
  input  logic           i_key_up,
  input  logic           i_grow,
  input  logic [9:0]     i_pos_x,
  input  logic [9:0]     i_pos_y,
  input  logic           i_snake_display,
  output logic [X_W-1:0] o_head_x,
  output logic [Y_W-1:0] o_head_y,
  output logic [L_W-1:0] o_length,
  output logic           o_step,
  output logic           o_hit_wall,
  output logic           o_hit_body,
  output logic [1:0]     o_snake_show
);

  logic [X_W-1:0]    r_seg_x [MAX_LEN];
  logic [Y_W-1:0]    r_seg_y [MAX_LEN];
  logic [L_W-1:0]    r_len;
  logic [2:0]        r_gpend;
  logic [TICK_W-1:0] r_tick;
  dir_t              r_dir;
  logic              r_wrap, r_step, r_hit_wall, r_hit_body;
  state_t            r_state, w_state_nxt;
  show_t             r_show, w_show;

  logic              w_restart, w_play, w_fire, w_q_vld, w_wall_hit, w_body_hit;
  logic              w_grow_now, w_move_ok, w_on_body;
  logic [TICK_W-1:0] w_period;
  dir_t              w_q_dir, w_dir_mv;
  logic [X_W-1:0]    w_nx;
  logic [Y_W-1:0]    w_ny;
  logic [L_W-1:0]    w_chk_len;
  logic [2:0]        w_gsat;
  logic [9:0]        w_cx, w_cy;

  assign w_restart = (i_game_status == GS_RESTART);
  assign w_play    = (i_game_status == GS_PLAY);

  always_comb begin
    case (i_speed_sel)
      2'd0:    w_period = TICK_W'(PERIOD0);
      2'd1:    w_period = TICK_W'(PERIOD1);
      2'd2:    w_period = TICK_W'(PERIOD2);
      default: w_period = TICK_W'(PERIOD3);
    endcase
  end

  // ">=" lets a shortened period fire on the very next cycle
  assign w_fire = (r_state == ST_RUN) && w_play && (r_tick >= w_period - TICK_W'(1));

  snake_dir_queue u_dir_queue (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_restart),
    .i_key_n   ({i_key_up, i_key_down, i_key_left, i_key_right}),
    .i_pop     (w_fire),
    .i_cur_dir (r_dir),
    .o_vld     (w_q_vld),
    .o_dir     (w_q_dir)
  );

  assign w_dir_mv = w_q_vld ? w_q_dir : r_dir;

  always_comb begin
    w_nx = r_seg_x[0];
    w_ny = r_seg_y[0];
    case (w_dir_mv)
      DIR_UP:   w_ny = (r_seg_y[0] == '0) ? Y_W'(GRID_H - 1) : r_seg_y[0] - Y_W'(1);
      DIR_DOWN: w_ny = (r_seg_y[0] == Y_W'(GRID_H - 1)) ? '0 : r_seg_y[0] + Y_W'(1);
      DIR_LEFT: w_nx = (r_seg_x[0] == '0) ? X_W'(GRID_W - 1) : r_seg_x[0] - X_W'(1);
      default:  w_nx = (r_seg_x[0] == X_W'(GRID_W - 1)) ? '0 : r_seg_x[0] + X_W'(1);
    endcase
  end

  assign w_wall_hit = !r_wrap && (w_nx == '0 || w_nx == X_W'(GRID_W - 1) ||
                                  w_ny == '0 || w_ny == Y_W'(GRID_H - 1));
  assign w_grow_now = (r_gpend != 3'd0 || i_grow) && (r_len < L_W'(MAX_LEN));
  // the tail vacates its cell unless this move grows the snake
  assign w_chk_len  = w_grow_now ? r_len : r_len - L_W'(1);
  assign w_gsat     = (r_gpend == 3'd7) ? 3'd7 : r_gpend + {2'b00, i_grow};

  always_comb begin
    w_body_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++)
      if (L_W'(i) < w_chk_len && r_seg_x[i] == w_nx && r_seg_y[i] == w_ny) w_body_hit = 1'b1;
  end

  assign w_move_ok = w_fire && !w_wall_hit && !w_body_hit;

  always_comb begin
    w_state_nxt = r_state;
    if (w_restart) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_play) w_state_nxt = ST_RUN;
        ST_RUN:  if (w_fire && (w_wall_hit || w_body_hit)) w_state_nxt = ST_DEAD;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= X_W'(INIT_X - i);
        r_seg_y[i] <= Y_W'(INIT_Y);
      end
      r_len      <= L_W'(INIT_LEN);
      r_gpend    <= 3'd0;
      r_tick     <= '0;
      r_dir      <= DIR_RIGHT;
      r_wrap     <= 1'b0;
      r_step     <= 1'b0;
      r_hit_wall <= 1'b0;
      r_hit_body <= 1'b0;
    end else if (w_restart) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= X_W'(INIT_X - i);
        r_seg_y[i] <= Y_W'(INIT_Y);
      end
      r_len      <= L_W'(INIT_LEN);
      r_gpend    <= 3'd0;
      r_tick     <= '0;
      r_dir      <= DIR_RIGHT;
      r_wrap     <= i_wrap_mode;
      r_step     <= 1'b0;
      r_hit_wall <= 1'b0;
      r_hit_body <= 1'b0;
    end else begin
      r_step <= w_move_ok;
      if (w_move_ok) begin
        for (int i = MAX_LEN - 1; i > 0; i--) begin
          r_seg_x[i] <= r_seg_x[i-1];
          r_seg_y[i] <= r_seg_y[i-1];
        end
        r_seg_x[0] <= w_nx;
        r_seg_y[0] <= w_ny;
        r_dir      <= w_dir_mv;
      end
      if (w_move_ok && w_grow_now) r_len <= r_len + L_W'(1);
      if (r_len == L_W'(MAX_LEN))        r_gpend <= 3'd0;
      else if (w_move_ok && w_grow_now)  r_gpend <= w_gsat - 3'd1;
      else                               r_gpend <= w_gsat;
      if (r_state == ST_RUN && w_play) r_tick <= w_fire ? '0 : r_tick + TICK_W'(1);
      if (w_fire && w_wall_hit)                r_hit_wall <= 1'b1;
      if (w_fire && !w_wall_hit && w_body_hit) r_hit_body <= 1'b1;
    end
  end

  always_comb begin
    w_cx      = i_pos_x >> CELL_SHIFT;
    w_cy      = i_pos_y >> CELL_SHIFT;
    w_on_body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++)
      if (L_W'(i) < r_len && w_cx == 10'(r_seg_x[i]) && w_cy == 10'(r_seg_y[i])) w_on_body = 1'b1;
    w_show = SHOW_NONE;
    if (w_cx < 10'(GRID_W) && w_cy < 10'(GRID_H)) begin
      if (!r_wrap && (w_cx == 10'd0 || w_cx == 10'(GRID_W - 1) ||
                      w_cy == 10'd0 || w_cy == 10'(GRID_H - 1)))
        w_show = SHOW_WALL;
      else if (i_snake_display && w_cx == 10'(r_seg_x[0]) && w_cy == 10'(r_seg_y[0]))
        w_show = SHOW_HEAD;
      else if (i_snake_display && w_on_body)
        w_show = SHOW_BODY;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_show <= SHOW_NONE;
    else       r_show <= w_show;
  end

  assign o_head_x     = r_seg_x[0];
  assign o_head_y     = r_seg_y[0];
  assign o_length     = r_len;
  assign o_step       = r_step;
  assign o_hit_wall   = r_hit_wall;
  assign o_hit_body   = r_hit_body;
  assign o_snake_show = r_show;

endmodule
